// File: rtl/pipelined_cpu_core.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_cpu_core
// Description : Four-stage (IF, ID, EX, WB) 16-bit-instruction CPU core with a
//               DATA_W-bit datapath, an 8-entry register file, an internal
//               writable instruction memory, full operand forwarding, branch
//               flush, halt and run-gating.
// Ports       : clk, rst_n         - clock, asynchronous active-low reset
//               run                - 1 advances the pipeline, 0 freezes all state
//               prog_we/addr/data  - instruction memory write port
//               result             - value held in the EX/WB register
//               result_valid       - register-writing instruction in WB and run
//               zero_flag          - last register-writing result was zero
//               halted             - sticky, set when HALT executes
//               pc                 - current fetch address
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_cpu_core #(
    parameter int  DATA_W     = 8,
    parameter int  IMEM_DEPTH = 16,
    localparam int AW         = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [15:0]       prog_data,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              zero_flag,
    output logic              halted,
    output logic [AW-1:0]     pc
);

    localparam int            c_sh_w    = $clog2(DATA_W);
    localparam logic [AW-1:0] c_pc_one  = AW'(1);

    localparam logic [3:0] c_op_add  = 4'd1;
    localparam logic [3:0] c_op_sub  = 4'd2;
    localparam logic [3:0] c_op_and  = 4'd3;
    localparam logic [3:0] c_op_or   = 4'd4;
    localparam logic [3:0] c_op_xor  = 4'd5;
    localparam logic [3:0] c_op_shl  = 4'd6;
    localparam logic [3:0] c_op_shr  = 4'd7;
    localparam logic [3:0] c_op_ldi  = 4'd8;
    localparam logic [3:0] c_op_beqz = 4'd9;
    localparam logic [3:0] c_op_halt = 4'd15;

    // Architectural state
    logic [15:0]       r_imem [IMEM_DEPTH];
    logic [DATA_W-1:0] r_regs [8];
    logic [AW-1:0]     r_pc;
    logic              r_halted;
    logic              r_zero;

    // IF/ID slot
    logic              r_ifid_valid;
    logic [15:0]       r_ifid_instr;
    logic [AW-1:0]     r_ifid_pc;

    // ID/EX slot
    logic              r_idex_valid;
    logic [3:0]        r_idex_op;
    logic [2:0]        r_idex_rd;
    logic [2:0]        r_idex_rs1;
    logic [2:0]        r_idex_rs2;
    logic [8:0]        r_idex_imm;
    logic [DATA_W-1:0] r_idex_a;
    logic [DATA_W-1:0] r_idex_b;
    logic [AW-1:0]     r_idex_pc;

    // EX/WB slot; the write flag already includes the slot-valid bit
    logic              r_exwb_we;
    logic [2:0]        r_exwb_rd;
    logic [DATA_W-1:0] r_exwb_result;

    logic [15:0]       w_fetch_instr;
    logic [2:0]        w_id_rs1;
    logic [2:0]        w_id_rs2;
    logic              w_wb_write;
    logic [DATA_W-1:0] w_id_a;
    logic [DATA_W-1:0] w_id_b;
    logic [DATA_W-1:0] w_ex_a;
    logic [DATA_W-1:0] w_ex_b;
    logic [c_sh_w-1:0] w_shamt;
    logic [DATA_W-1:0] w_alu;
    logic              w_alu_writes;
    logic              w_ex_writes;
    logic [DATA_W-1:0] w_ex_result;
    logic              w_ex_taken;
    logic              w_ex_halt;
    logic              w_flush;
    logic [AW-1:0]     w_branch_target;

    // ------------------------------------------------------------------
    // Instruction memory: not reset; a same-edge write is not seen by the
    // fetch of that cycle because the read is of the pre-edge contents.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (prog_we) begin
            r_imem[prog_addr] <= prog_data;
        end
    end

    assign w_fetch_instr = r_imem[r_pc];

    // ------------------------------------------------------------------
    // ID: register read with write-through from the WB stage
    // ------------------------------------------------------------------
    assign w_id_rs1   = r_ifid_instr[8:6];
    assign w_id_rs2   = r_ifid_instr[5:3];
    assign w_wb_write = r_exwb_we & run;

    assign w_id_a = (w_wb_write && (r_exwb_rd == w_id_rs1)) ? r_exwb_result : r_regs[w_id_rs1];
    assign w_id_b = (w_wb_write && (r_exwb_rd == w_id_rs2)) ? r_exwb_result : r_regs[w_id_rs2];

    // ------------------------------------------------------------------
    // EX: forward the EX/WB result when it targets an operand register.
    // Together with the ID write-through this covers every RAW distance,
    // so the pipeline never stalls.
    // ------------------------------------------------------------------
    assign w_ex_a  = (r_exwb_we && (r_exwb_rd == r_idex_rs1)) ? r_exwb_result : r_idex_a;
    assign w_ex_b  = (r_exwb_we && (r_exwb_rd == r_idex_rs2)) ? r_exwb_result : r_idex_b;
    assign w_shamt = w_ex_b[c_sh_w-1:0];

    always_comb begin
        w_alu        = '0;
        w_alu_writes = 1'b1;
        case (r_idex_op)
            c_op_add: w_alu = w_ex_a + w_ex_b;
            c_op_sub: w_alu = w_ex_a - w_ex_b;
            c_op_and: w_alu = w_ex_a & w_ex_b;
            c_op_or:  w_alu = w_ex_a | w_ex_b;
            c_op_xor: w_alu = w_ex_a ^ w_ex_b;
            c_op_shl: w_alu = w_ex_a << w_shamt;
            c_op_shr: w_alu = w_ex_a >> w_shamt;
            c_op_ldi: w_alu = DATA_W'(r_idex_imm);
            default:  w_alu_writes = 1'b0;
        endcase
    end

    // Non-writing slots carry a zero result so the EX/WB value stays clean
    assign w_ex_writes = r_idex_valid & w_alu_writes;
    assign w_ex_result = w_ex_writes ? w_alu : '0;

    assign w_ex_taken      = r_idex_valid && (r_idex_op == c_op_beqz) && (w_ex_a == '0);
    assign w_ex_halt       = r_idex_valid && (r_idex_op == c_op_halt);
    assign w_flush         = w_ex_taken | w_ex_halt;
    // Size cast of the signed offset sign-extends, then wraps modulo depth
    assign w_branch_target = r_idex_pc + AW'($signed(r_idex_imm[5:0]));

    // ------------------------------------------------------------------
    // Pipeline, pc and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= '0;
            r_halted      <= 1'b0;
            r_zero        <= 1'b0;
            r_ifid_valid  <= 1'b0;
            r_ifid_instr  <= '0;
            r_ifid_pc     <= '0;
            r_idex_valid  <= 1'b0;
            r_idex_op     <= '0;
            r_idex_rd     <= '0;
            r_idex_rs1    <= '0;
            r_idex_rs2    <= '0;
            r_idex_imm    <= '0;
            r_idex_a      <= '0;
            r_idex_b      <= '0;
            r_idex_pc     <= '0;
            r_exwb_we     <= 1'b0;
            r_exwb_rd     <= '0;
            r_exwb_result <= '0;
        end else if (run) begin
            // Fetch address: HALT freezes at its own address + 1
            if (w_ex_halt) begin
                r_pc <= r_idex_pc + c_pc_one;
            end else if (w_ex_taken) begin
                r_pc <= w_branch_target;
            end else if (!r_halted) begin
                r_pc <= r_pc + c_pc_one;
            end

            // IF -> ID
            if (w_flush || r_halted) begin
                r_ifid_valid <= 1'b0;
            end else begin
                r_ifid_valid <= 1'b1;
                r_ifid_instr <= w_fetch_instr;
                r_ifid_pc    <= r_pc;
            end

            // ID -> EX
            r_idex_valid <= r_ifid_valid & ~w_flush;
            r_idex_op    <= r_ifid_instr[15:12];
            r_idex_rd    <= r_ifid_instr[11:9];
            r_idex_rs1   <= w_id_rs1;
            r_idex_rs2   <= w_id_rs2;
            r_idex_imm   <= r_ifid_instr[8:0];
            r_idex_a     <= w_id_a;
            r_idex_b     <= w_id_b;
            r_idex_pc    <= r_ifid_pc;

            // EX -> WB
            r_exwb_we     <= w_ex_writes;
            r_exwb_rd     <= r_idex_rd;
            r_exwb_result <= w_ex_result;

            if (w_ex_writes) begin
                r_zero <= (w_ex_result == '0);
            end
            if (w_ex_halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file, written as the WB slot retires
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_write) begin
            r_regs[r_exwb_rd] <= r_exwb_result;
        end
    end

    assign result       = r_exwb_result;
    assign result_valid = w_wb_write;
    assign zero_flag    = r_zero;
    assign halted       = r_halted;
    assign pc           = r_pc;

endmodule
`default_nettype wire
